// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer gain loader.
// Command byte layout, FSM state encodings and the gain word type.
package eq_pkg;

    localparam int CMD_RD_BIT     = 7;
    localparam int CMD_COMMIT_BIT = 6;
    localparam int MAX_FILTERS    = 16;

    typedef logic [15:0] gain_t;

    typedef enum logic [2:0] {
        P_CMD,
        P_WR_LSB,
        P_WR_MSB,
        P_RD_MSB,
        P_DRAIN
    } parser_state_e;

    typedef enum logic [1:0] {
        C_IDLE,
        C_ARMED,
        C_GUARD,
        C_BURST
    } commit_state_e;

    function automatic logic index_ok(input logic [3:0] idx, input int n);
        return int'(idx) < n;
    endfunction

endpackage

// File: rtl/eq_gain_loader_if.sv
// CPU byte link between the host byte receiver (master) and the gain loader (slave).
interface eq_gain_loader_if;

    logic       cpu_frame;
    logic       cpu_byte_en;
    logic [7:0] cpu_byte;
    logic [7:0] rd_byte;
    logic       rd_byte_valid;

    modport master (
        output cpu_frame, cpu_byte_en, cpu_byte,
        input  rd_byte, rd_byte_valid
    );

    modport slave (
        input  cpu_frame, cpu_byte_en, cpu_byte,
        output rd_byte, rd_byte_valid
    );

endinterface

// File: rtl/eq_cpu_byte_parser.sv
// Frame-level command parser: turns the CPU byte stream into write, read and
// commit strobes. Strobes are combinational and valid in the cycle of the byte.
module eq_cpu_byte_parser
    import eq_pkg::*;
#(
    parameter int num_of_filters = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cpu_frame,
    input  logic       cpu_byte_en,
    input  logic [7:0] cpu_byte,
    output logic       wr_stb,
    output logic [3:0] wr_idx,
    output gain_t      wr_val,
    output logic       rd_req,
    output logic       rd_hi,
    output logic [3:0] rd_idx,
    output logic       commit_req,
    output logic       cmd_err
);

    parser_state_e state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    lsb_q, lsb_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, whatever the process order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= P_CMD;
            idx_q   <= '0;
            lsb_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lsb_q   <= lsb_d;
        end
    end

    // NOTE: every output and next-state variable gets a default before the case,
    // otherwise an unassigned path would infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        lsb_d      = lsb_q;
        wr_stb     = 1'b0;
        wr_idx     = idx_q;
        wr_val     = {cpu_byte, lsb_q};
        rd_req     = 1'b0;
        rd_hi      = 1'b0;
        rd_idx     = idx_q;
        commit_req = 1'b0;
        cmd_err    = 1'b0;

        if (!cpu_frame) begin
            state_d = P_CMD;
        end else if (cpu_byte_en) begin
            unique case (state_q)
                P_CMD: begin
                    idx_d = cpu_byte[3:0];
                    if (cpu_byte[CMD_COMMIT_BIT]) begin
                        commit_req = 1'b1;
                        state_d    = P_DRAIN;
                    end else if (!index_ok(cpu_byte[3:0], num_of_filters)) begin
                        cmd_err = 1'b1;
                        state_d = P_DRAIN;
                    end else if (cpu_byte[CMD_RD_BIT]) begin
                        rd_req  = 1'b1;
                        rd_idx  = cpu_byte[3:0];
                        state_d = P_RD_MSB;
                    end else begin
                        state_d = P_WR_LSB;
                    end
                end
                P_WR_LSB: begin
                    lsb_d   = cpu_byte;
                    state_d = P_WR_MSB;
                end
                P_WR_MSB: begin
                    wr_stb  = 1'b1;
                    state_d = P_DRAIN;
                end
                P_RD_MSB: begin
                    rd_req  = 1'b1;
                    rd_hi   = 1'b1;
                    state_d = P_DRAIN;
                end
                P_DRAIN: state_d = P_DRAIN;
                default: state_d = P_CMD;
            endcase
        end
    end

endmodule

// File: rtl/eq_gain_loader.sv
// Equalizer gain loader: staged/active gain banks with a commit FSM that
// writes dirty entries to the gain RAM in a burst aligned to a sample boundary.
module eq_gain_loader
    import eq_pkg::*;
#(
    parameter int    num_of_filters = 4,
    parameter gain_t default_gain   = 16'h0100
) (
    input  logic            clk,
    input  logic            reset,
    eq_gain_loader_if.slave cpu,
    input  logic            r_data_en,
    output logic            eq_wr,
    output logic [3:0]      eq_wr_sel,
    output logic [7:0]      eq_gain_lsb,
    output logic [7:0]      eq_gain_msb,
    output logic            busy,
    output logic            commit_done,
    output logic            cmd_err
);

    localparam logic [4:0] GUARD_LAST = 5'(num_of_filters + 1);
    localparam logic [3:0] SCAN_LAST  = 4'(num_of_filters - 1);

    logic       wr_stb;
    logic [3:0] wr_idx;
    gain_t      wr_val;
    logic       rd_req;
    logic       rd_hi;
    logic [3:0] rd_idx;
    logic       commit_req;
    logic       parse_err;

    eq_cpu_byte_parser #(
        .num_of_filters (num_of_filters)
    ) u_parser (
        .clk         (clk),
        .reset       (reset),
        .cpu_frame   (cpu.cpu_frame),
        .cpu_byte_en (cpu.cpu_byte_en),
        .cpu_byte    (cpu.cpu_byte),
        .wr_stb      (wr_stb),
        .wr_idx      (wr_idx),
        .wr_val      (wr_val),
        .rd_req      (rd_req),
        .rd_hi       (rd_hi),
        .rd_idx      (rd_idx),
        .commit_req  (commit_req),
        .cmd_err     (parse_err)
    );

    gain_t                  staged [MAX_FILTERS];
    gain_t                  active [MAX_FILTERS];
    logic [MAX_FILTERS-1:0] dirty;

    commit_state_e cstate_q, cstate_d;
    logic [4:0]    guard_q, guard_d;
    logic [3:0]    scan_q, scan_d;
    logic          scan_active;
    logic          last_scan;
    logic          done_pend;
    gain_t         rd_gain;

    assign scan_active = (cstate_q == C_BURST);
    assign last_scan   = scan_active && (scan_q == SCAN_LAST);
    assign rd_gain     = active[rd_idx];

    // Reset lands in C_BURST so the gain RAM is initialised without waiting for a sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            cstate_q <= C_BURST;
            guard_q  <= '0;
            scan_q   <= '0;
        end else begin
            cstate_q <= cstate_d;
            guard_q  <= guard_d;
            scan_q   <= scan_d;
        end
    end

    always_comb begin
        cstate_d = cstate_q;
        guard_d  = guard_q;
        scan_d   = scan_q;
        unique case (cstate_q)
            C_IDLE: begin
                if (commit_req) cstate_d = C_ARMED;
            end
            C_ARMED: begin
                if (r_data_en) begin
                    cstate_d = C_GUARD;
                    guard_d  = '0;
                end
            end
            C_GUARD: begin
                // Hold off until the equalizer's read sweep for this sample is over.
                if (guard_q == GUARD_LAST) begin
                    cstate_d = C_BURST;
                    scan_d   = '0;
                end else begin
                    guard_d = guard_q + 5'd1;
                end
            end
            C_BURST: begin
                if (scan_q == SCAN_LAST) cstate_d = C_IDLE;
                else                     scan_d   = scan_q + 4'd1;
            end
            default: cstate_d = C_IDLE;
        endcase
    end

    // NOTE: the gain banks are small register arrays, so they take a real reset
    // value; a RAM-style bank could not be reset this way.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_FILTERS; i++) begin
                staged[i] <= default_gain;
                active[i] <= default_gain;
            end
            dirty <= '1;
        end else begin
            if (scan_active) begin
                if (dirty[scan_q]) active[scan_q] <= staged[scan_q];
                dirty[scan_q] <= 1'b0;
            end
            // Placed after the scan so a host write to the scanned entry keeps it dirty.
            if (wr_stb) begin
                staged[wr_idx] <= wr_val;
                dirty[wr_idx]  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eq_wr             <= 1'b0;
            eq_wr_sel         <= '0;
            eq_gain_lsb       <= '0;
            eq_gain_msb       <= '0;
            busy              <= 1'b0;
            done_pend         <= 1'b0;
            commit_done       <= 1'b0;
            cmd_err           <= 1'b0;
            cpu.rd_byte       <= '0;
            cpu.rd_byte_valid <= 1'b0;
        end else begin
            eq_wr <= scan_active && dirty[scan_q];
            if (scan_active) begin
                eq_wr_sel   <= scan_q;
                eq_gain_lsb <= staged[scan_q][7:0];
                eq_gain_msb <= staged[scan_q][15:8];
            end
            busy        <= (cstate_d != C_IDLE) || last_scan;
            done_pend   <= last_scan;
            commit_done <= done_pend;
            cmd_err     <= parse_err;
            cpu.rd_byte_valid <= rd_req;
            if (rd_req) cpu.rd_byte <= rd_hi ? rd_gain[15:8] : rd_gain[7:0];
        end
    end

endmodule

// File: tb/tb_eq_gain_loader.sv
// Directed bench for eq_gain_loader: scoreboard queues for gain RAM writes and
// readback bytes, each entry carrying the cycle it must appear in.
module tb_eq_gain_loader;
    import eq_pkg::*;

    localparam int N = 4;

    typedef struct {
        logic [3:0] sel;
        gain_t      gain;
        int         cyc;
    } wr_exp_t;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } rd_exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       r_data_en;
    logic       eq_wr;
    logic [3:0] eq_wr_sel;
    logic [7:0] eq_gain_lsb;
    logic [7:0] eq_gain_msb;
    logic       busy;
    logic       commit_done;
    logic       cmd_err;

    eq_gain_loader_if cpu_if ();

    eq_gain_loader #(
        .num_of_filters (N),
        .default_gain   (16'h0100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cpu         (cpu_if.slave),
        .r_data_en   (r_data_en),
        .eq_wr       (eq_wr),
        .eq_wr_sel   (eq_wr_sel),
        .eq_gain_lsb (eq_gain_lsb),
        .eq_gain_msb (eq_gain_msb),
        .busy        (busy),
        .commit_done (commit_done),
        .cmd_err     (cmd_err)
    );

    always #5 clk = ~clk;

    int      cyc = 0;
    int      checks = 0;
    int      errors = 0;
    int      err_cnt = 0;
    wr_exp_t wr_q[$];
    rd_exp_t rd_q[$];
    wr_exp_t mon_we;
    rd_exp_t mon_re;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (eq_wr === 1'b1) begin
            check("wr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                mon_we = wr_q.pop_front();
                check("wr_data", {12'h0, eq_wr_sel, eq_gain_msb, eq_gain_lsb},
                      {12'h0, mon_we.sel, mon_we.gain});
                check("wr_cycle", cyc, mon_we.cyc);
            end
        end
        if (cpu_if.rd_byte_valid === 1'b1) begin
            check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) begin
                mon_re = rd_q.pop_front();
                check("rd_byte", {24'h0, cpu_if.rd_byte}, {24'h0, mon_re.data});
                check("rd_cycle", cyc, mon_re.cyc);
            end
        end
        if (cmd_err === 1'b1) err_cnt++;
    end

    task automatic send_byte(input logic [7:0] b, input bit exp_rd = 1'b0,
                             input logic [7:0] rd_exp = 8'h00, input bit with_rde = 1'b0);
        @(negedge clk);
        if (exp_rd) rd_q.push_back('{data: rd_exp, cyc: cyc + 1});
        cpu_if.cpu_frame   = 1'b1;
        cpu_if.cpu_byte_en = 1'b1;
        cpu_if.cpu_byte    = b;
        r_data_en          = with_rde;
        @(negedge clk);
        cpu_if.cpu_byte_en = 1'b0;
        r_data_en          = 1'b0;
    endtask

    task automatic end_frame();
        cpu_if.cpu_frame = 1'b0;
        @(negedge clk);
    endtask

    task automatic write_gain(input logic [3:0] idx, input gain_t val);
        send_byte({4'h0, idx});
        send_byte(val[7:0]);
        send_byte(val[15:8]);
        end_frame();
    endtask

    task automatic read_gain(input logic [3:0] idx, input gain_t exp, input string tag);
        send_byte({4'h8, idx}, 1'b1, exp[7:0]);
        send_byte(8'h00, 1'b1, exp[15:8]);
        end_frame();
        check({tag, "_drained"}, rd_q.size(), 0);
    endtask

    task automatic commit_frame(input bit with_rde);
        send_byte(8'h40, 1'b0, 8'h00, with_rde);
        end_frame();
    endtask

    task automatic pulse_rde(output int t);
        @(negedge clk);
        r_data_en = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        r_data_en = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (commit_done !== 1'b1 && n < 200);
        check({tag, "_done"}, {31'h0, commit_done}, 32'd1);
        check({tag, "_done_cyc"}, cyc, exp_cyc);
        check({tag, "_busy_low"}, {31'h0, busy}, 32'd0);
        check({tag, "_wr_drained"}, wr_q.size(), 0);
    endtask

    initial begin
        int t;
        int err_before;

        reset              = 1'b1;
        r_data_en          = 1'b0;
        cpu_if.cpu_frame   = 1'b0;
        cpu_if.cpu_byte_en = 1'b0;
        cpu_if.cpu_byte    = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {27'h0, eq_wr, busy, commit_done, cmd_err, cpu_if.rd_byte_valid}, 32'd0);
        check("rst_data", {12'h0, eq_wr_sel, eq_gain_msb, eq_gain_lsb}, 32'd0);

        // Init burst interrupted after two entries by a second reset.
        reset = 1'b0;
        for (int i = 0; i < 2; i++) wr_q.push_back('{sel: 4'(i), gain: 16'h0100, cyc: cyc + 1 + i});
        @(negedge clk);
        check("busy_rise", {31'h0, busy}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_ctrl", {29'h0, eq_wr, busy, commit_done}, 32'd0);
        check("midrst_q", wr_q.size(), 0);
        @(negedge clk);

        // Full init burst after release.
        reset = 1'b0;
        t = cyc;
        for (int i = 0; i < N; i++) wr_q.push_back('{sel: 4'(i), gain: 16'h0100, cyc: t + 1 + i});
        wait_done(t + N + 1, "init");

        // Staged write is invisible to readback until committed.
        read_gain(4'd2, 16'h0100, "rd_pre");
        write_gain(4'd2, 16'h1234);
        read_gain(4'd2, 16'h0100, "rd_staged");

        // Two commits before the sample strobe, the first with a same-cycle strobe.
        commit_frame(1'b1);
        commit_frame(1'b0);
        check("armed_busy", {31'h0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        check("armed_q", wr_q.size(), 0);
        pulse_rde(t);
        wr_q.push_back('{sel: 4'd2, gain: 16'h1234, cyc: t + N + 3 + 2});
        wait_done(t + 2 * N + 3, "commit1");
        read_gain(4'd2, 16'h1234, "rd_post");

        // Out-of-range write and read, then a frame dropped after the lsb byte.
        err_before = err_cnt;
        send_byte(8'h05);
        send_byte(8'h22);
        send_byte(8'h33);
        end_frame();
        check("err_wr_idx", err_cnt, err_before + 1);
        send_byte(8'h87);
        send_byte(8'h00);
        end_frame();
        check("err_rd_idx", err_cnt, err_before + 2);
        send_byte(8'h03);
        send_byte(8'hAA);
        end_frame();
        read_gain(4'd3, 16'h0100, "rd_after_drop");
        commit_frame(1'b0);
        pulse_rde(t);
        wait_done(t + 2 * N + 3, "commit_clean");

        // Host write to index 1 lands on the cycle index 1 is scanned.
        commit_frame(1'b0);
        pulse_rde(t);
        send_byte(8'h01);
        send_byte(8'hEF);
        while (cyc < t + N + 3) @(negedge clk);
        cpu_if.cpu_byte_en = 1'b1;
        cpu_if.cpu_byte    = 8'hBE;
        @(negedge clk);
        cpu_if.cpu_byte_en = 1'b0;
        end_frame();
        wait_done(t + 2 * N + 3, "collide");
        commit_frame(1'b0);
        pulse_rde(t);
        wr_q.push_back('{sel: 4'd1, gain: 16'hBEEF, cyc: t + N + 3 + 1});
        wait_done(t + 2 * N + 3, "commit2");
        read_gain(4'd1, 16'hBEEF, "rd_beef");

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/eq_gain_loader.md
# eq_gain_loader

Host-side writer for the equalizer gain RAM. It parses a byte-stream command interface from the CPU link and keeps a staged and an active copy of every gain. Staged gains are committed as a burst of `eq_wr` / `eq_wr_sel` / `eq_gain_lsb` / `eq_gain_msb` writes, aligned to a sample boundary, so the equalizer never accumulates one sample with a mix of old and new gains. The block sits between the CPU byte receiver and the equalizer gain stage.

## Interface
Parameters:
- `num_of_filters`, 4: number of gain entries, 1..16.
- `default_gain`, 16'h0100: gain loaded into every entry at reset.

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_frame`  in  1  high for the duration of one CPU transaction.
- `cpu_byte_en`  in  1  one-cycle strobe; `cpu_byte` is valid.
- `cpu_byte`  in  8  command or data byte.
- `r_data_en`  in  1  sample strobe, the same strobe the equalizer uses to start its gain read sequence.
- `rd_byte`  out  8  readback byte.
- `rd_byte_valid`  out  1  one-cycle strobe; `rd_byte` is valid.
- `eq_wr`  out  1  gain RAM write enable.
- `eq_wr_sel`  out  4  gain RAM write address.
- `eq_gain_lsb`  out  8  gain bits 7:0.
- `eq_gain_msb`  out  8  gain bits 15:8.
- `busy`  out  1  a commit or init burst is pending or running.
- `commit_done`  out  1  one-cycle strobe at the end of a burst.
- `cmd_err`  out  1  one-cycle strobe on an illegal command.

## Operation
**Command byte** (first byte of each frame):
- bit7 RD, bit6 COMMIT, bits3:0 index. Bits 5:4 are ignored.
- COMMIT has priority over RD.

**Write** (RD=0, COMMIT=0): cmd, lsb, msb.
- `staged[index] <= {msb, lsb}` on the msb byte.
- `dirty[index] <= 1` on the same byte.

**Read** (RD=1): cmd, then one dummy byte.
- The cmd byte returns `active[index][7:0]`.
- The dummy byte returns `active[index][15:8]`.

**Commit** (COMMIT=1): single byte.
- Arms the commit FSM. If it is already armed or running, the request merges: no error and no second burst.
- Further bytes in the same frame are ignored.

**Errors:** an index ≥ `num_of_filters` on RD or write pulses `cmd_err`. The parser then goes to DRAIN.

**Frame drop:** `cpu_frame` low in any parser state returns the parser to CMD and discards a partial write. Bytes received in DRAIN are ignored.

**Parser FSM:** CMD → WR_LSB → WR_MSB → DRAIN; CMD → RD_MSB → DRAIN; CMD → DRAIN (commit or error).

**Commit FSM:** C_IDLE → C_ARMED → C_GUARD → C_BURST → C_IDLE.
- C_ARMED waits for the next `r_data_en`. A strobe in the same cycle as the commit byte does not count.
- C_GUARD counts `num_of_filters`+2 cycles, so the equalizer's read sweep completes.
- C_BURST scans index 0..`num_of_filters`-1, one index per cycle. For a dirty index it drives `eq_wr`=1 and sets `active <= staged`. A clean index produces `eq_wr`=0.
- On scan, `dirty` is cleared unless a host write to that index lands in the same cycle; the host write wins and `dirty` stays 1.

**Reset:**
- `staged` = `active` = `default_gain` and every `dirty` bit is set.
- The commit FSM goes straight to C_BURST with no wait for `r_data_en`, which initialises the gain RAM.
- Reset asserted mid-burst aborts the burst; the init burst restarts after reset is released.

## Timing
- **Reset values:** all outputs 0 while `reset` is high. `busy` rises on the first cycle after release.
- **Readback latency:** `rd_byte_valid` pulses 1 cycle after the corresponding `cpu_byte_en`.
- **Write outputs:** `eq_wr`, `eq_wr_sel`, `eq_gain_lsb` and `eq_gain_msb` are all registered and valid in the same cycle.
- **Burst timing:** with `r_data_en` at cycle t, the first scan cycle is t+`num_of_filters`+3 and the burst lasts `num_of_filters` cycles.
- **End of burst:** `commit_done` pulses 1 cycle after the last scan cycle; `busy` falls in that same cycle.
- **Init burst:** the first scan cycle is the first cycle after reset release.

## Structure
- Package `eq_pkg` holds:
  - constants `CMD_RD_BIT`=7, `CMD_COMMIT_BIT`=6, `MAX_FILTERS`=16;
  - the parser and commit state enums;
  - the 16-bit `gain_t` typedef.
- Sub-module `eq_cpu_byte_parser`: the parser FSM. It emits decoded strobes `wr_stb` (with index and value), `rd_req` and `commit_req`.
- The top level holds the staged/active/dirty bank and the commit FSM.

## Test plan
- **Reset init:** release reset → `eq_wr` high for 4 consecutive cycles, sel 0,1,2,3, gain 16'h0100 each; then `commit_done`.
- **Write + commit:** write index 2 = 16'h1234, COMMIT, `r_data_en` at cycle t → single `eq_wr` at t+7+2 with sel 2, lsb 8'h34, msb 8'h12.
- **Readback:** read index 2 before commit → 8'h00, 8'h01; after commit → 8'h34, 8'h12.
- **Errors and aborts:**
  - cmd 8'h05 with `num_of_filters`=4 → `cmd_err` pulse and no `dirty` change.
  - Frame dropped after the lsb byte → no write.
- **Scan collision:** host write to index 1 = 16'hBEEF in the same cycle index 1 is scanned → `dirty[1]` stays set; the next commit writes 16'hBEEF.
- **Reset mid-burst and merged commits:**
  - Reset asserted mid-burst → outputs 0; the full init burst reruns.
  - Two COMMITs before `r_data_en` → exactly one burst.
